// File: rtl/spi_master.sv
// spi_master: host end of the serial register bus; turns parallel read/write requests into
// start/address/R-W/data frames. Define SPI_MASTER_MISO_SYNC_EN for a 2-flop spi_miso synchronizer.
module spi_master #(
    parameter int RD_DELAY     = 0,
    parameter int FLUSH_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       req,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    logic miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int SYNC_LAT = 2;
    logic miso_p0, miso_p1;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            miso_p0 <= 1'b0;
            miso_p1 <= 1'b0;
        end else begin
            miso_p0 <= spi_miso;
            miso_p1 <= miso_p0;
        end
    end

    assign miso_s = miso_p1;
`else
    localparam int SYNC_LAT = 0;
    assign miso_s = spi_miso;
`endif

    // The 5-bit counter limits FLUSH_CYCLES to 32 and RD_DELAY + sync latency to 22.
    localparam logic [4:0] FLUSH_LAST = 5'(FLUSH_CYCLES - 1);
    localparam logic [4:0] RD_FIRST   = 5'(2 + RD_DELAY + SYNC_LAT);
    localparam logic [4:0] RD_LAST    = 5'(9 + RD_DELAY + SYNC_LAT);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_HDR,
        S_PAD,
        S_WDATA,
        S_RDATA,
        S_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        mosi_nxt;
    logic [5:0]  hdr;
    logic        we_q;
    logic [7:0]  shreg;
    logic        load, hdr_shift, sh_shift, rd_load;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign ready = (state == S_IDLE);
    assign done  = (state == S_GAP);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= S_FLUSH;
            cnt      <= '0;
            spi_mosi <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            spi_mosi <= mosi_nxt;
            if (rd_load)
                rd_data <= {shreg[6:0], miso_s};
        end
    end

    // The start bit leaves directly from IDLE, so hdr only holds the six bits that follow it.
    always_ff @(posedge clk) begin
        if (load) begin
            hdr   <= {addr[6:2], we};
            we_q  <= we;
            shreg <= wr_data;
        end else begin
            if (hdr_shift)
                hdr <= {hdr[4:0], 1'b0};
            if (sh_shift)
                shreg <= {shreg[6:0], miso_s};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mosi_nxt  = 1'b0;
        load      = 1'b0;
        hdr_shift = 1'b0;
        sh_shift  = 1'b0;
        rd_load   = 1'b0;
        case (state)
            S_FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            S_IDLE: begin
                if (req) begin
                    load      = 1'b1;
                    mosi_nxt  = 1'b1;
                    state_nxt = S_HDR;
                    cnt_nxt   = '0;
                end
            end
            S_HDR: begin
                mosi_nxt  = hdr[5];
                hdr_shift = 1'b1;
                if (cnt == 5'd5) begin
                    state_nxt = S_PAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            S_PAD: begin
                state_nxt = we_q ? S_WDATA : S_RDATA;
                cnt_nxt   = '0;
            end
            S_WDATA: begin
                if (cnt == 5'd8) begin
                    state_nxt = S_GAP;
                end else begin
                    mosi_nxt = shreg[7];
                    sh_shift = 1'b1;
                    cnt_nxt  = cnt + 5'd1;
                end
            end
            S_RDATA: begin
                // Counting starts the edge after PAD; the first RD_FIRST edges cover slave turnaround.
                cnt_nxt = cnt + 5'd1;
                if (cnt >= RD_FIRST)
                    sh_shift = 1'b1;
                if (cnt == RD_LAST) begin
                    rd_load   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: state_nxt = S_FLUSH;
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized bench for spi_master with a behavioural serial slave, a return-path
// delay chain and a reference register map; read latency follows SPI_MASTER_MISO_SYNC_EN.
`timescale 1ns/1ps
module tb_spi_master;
    localparam int RD_DELAY     = 3;
    localparam int FLUSH_CYCLES = 20;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int S_LAT = 2;
`else
    localparam int S_LAT = 0;
`endif
    localparam int D = RD_DELAY + S_LAT;

    logic       clk     = 1'b0;
    logic       reset_l = 1'b0;
    logic       req     = 1'b0;
    logic       we      = 1'b0;
    logic [6:0] addr    = '0;
    logic [7:0] wr_data = '0;
    logic       ready, done, spi_mosi, spi_miso;
    logic [7:0] rd_data;

    spi_master #(.RD_DELAY(RD_DELAY), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wr_data  (wr_data),
        .ready    (ready),
        .done     (done),
        .rd_data  (rd_data),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Return path: slave output through RD_DELAY board flops.
    logic       slv_dout = 1'b0;
    logic [7:0] dregs    = '0;
    logic [8:0] dchain;
    assign dchain   = {dregs, slv_dout};
    assign spi_miso = dchain[RD_DELAY];
    always @(posedge clk) dregs <= dchain[7:0];

    logic [7:0]  slv_mem [32];
    logic [12:0] slv_wr_q [$];
    int          slv_rd_cnt = 0;

    // Slave: frame decoder driving read data two edges after the R/W bit.
    initial begin : slave
        logic [5:0] hb;
        logic [7:0] sd;
        forever begin
            @(posedge clk);
            if (spi_mosi === 1'b1) begin
                for (int i = 5; i >= 0; i--) begin
                    @(posedge clk);
                    hb[i] = spi_mosi;
                end
                @(posedge clk);
                if (hb[0]) begin
                    for (int i = 7; i >= 0; i--) begin
                        @(posedge clk);
                        sd[i] = spi_mosi;
                    end
                    slv_mem[hb[5:1]] = sd;
                    slv_wr_q.push_back({hb[5:1], sd});
                end else begin
                    slv_rd_cnt++;
                    for (int i = 7; i >= 0; i--) begin
                        @(posedge clk);
                        #1 slv_dout = slv_mem[hb[5:1]][i];
                    end
                    @(posedge clk);
                    #1 slv_dout = 1'b0;
                end
            end
        end
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [32];
    logic [7:0] last_rd = '0;
    int         exp_rd_cnt = 0;
    int         rel = 0;
    int         last_acc = 0;
    int         prev_len = 0;
    bit         prev_held = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_flush();
        reset_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mosi", 32'(spi_mosi), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        reset_l   = 1'b1;
        rel       = cyc;
        last_rd   = '0;
        prev_held = 1'b0;
        for (int k = 1; k < FLUSH_CYCLES; k++) begin
            @(posedge clk);
            #1;
            check("flush_ready", 32'(ready), 0);
            check("flush_mosi", 32'(spi_mosi), 0);
        end
        @(posedge clk);
        #1;
        check("flush_end_ready", 32'(ready), 1);
        check("flush_end_mosi", 32'(spi_mosi), 0);
    endtask

    // One transaction, checked bit by bit against the frame rules; called at posedge+1.
    task automatic txn(input bit w, input logic [6:0] a, input logic [7:0] d, input bit hold);
        logic [6:0] hdr;
        logic       exp_bit;
        int         edone, n, prev_acc;
        hdr      = {1'b1, a[6:2], w};
        edone    = w ? 16 : 17 + D;
        prev_acc = last_acc;
        req = 1'b1; we = w; addr = a; wr_data = d;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ready !== 1'b1) begin
            check("ready_timeout", 32'(ready), 1);
            req       = 1'b0;
            prev_held = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (prev_held)
            check("b2b_period", 32'(last_acc - prev_acc), 32'(prev_len));
        req = hold; we = 1'($urandom); addr = 7'($urandom); wr_data = 8'($urandom);
        check("start_bit", 32'(spi_mosi), 1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check("hdr_bit", 32'(spi_mosi), 32'(hdr[6-k]));
            check("busy", 32'(ready), 0);
        end
        for (int k = 7; k <= edone; k++) begin
            @(posedge clk);
            #1;
            exp_bit = (w && k >= 8 && k <= 15) ? d[15-k] : 1'b0;
            check("frame_bit", 32'(spi_mosi), 32'(exp_bit));
            check("done", 32'(done), 32'(k == edone));
            check("busy", 32'(ready), 0);
        end
        if (w) begin
            check("rd_hold", 32'(rd_data), 32'(last_rd));
            check("slv_wr_cnt", slv_wr_q.size(), 1);
            if (slv_wr_q.size() > 0)
                check("slv_wr", 32'(slv_wr_q.pop_front()), 32'({a[6:2], d}));
            ref_mem[a[6:2]] = d;
        end else begin
            exp_rd_cnt++;
            check("rd_data", 32'(rd_data), 32'(ref_mem[a[6:2]]));
            check("slv_rd_cnt", slv_rd_cnt, exp_rd_cnt);
            last_rd = ref_mem[a[6:2]];
        end
        @(posedge clk);
        #1;
        check("ready_back", 32'(ready), 1);
        check("done_end", 32'(done), 0);
        prev_len  = edone + 2;
        prev_held = hold;
    endtask

    initial begin : main
        logic [7:0] v;
        logic [6:0] ra;
        logic [7:0] rv;
        bit         rw, hold;
        int         n;
        for (int i = 0; i < 32; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
        ref_mem[2] = 8'h3C;
        slv_mem[2] = 8'h3C;

        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 7'h54; wr_data = 8'hA5;
        reset_flush();
        txn(1'b1, 7'h54, 8'hA5, 1'b0);
        check("first_accept", 32'(last_acc - rel), FLUSH_CYCLES + 1);
        txn(1'b0, 7'h08, 8'h00, 1'b0);
        txn(1'b1, 7'h7C, 8'hFF, 1'b1);
        txn(1'b0, 7'h7C, 8'h00, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 7'($urandom);
            rv   = 8'($urandom);
            hold = (i < 23) && ($urandom_range(0, 3) == 0);
            txn(rw, ra, rv, hold);
        end

        // Abort a write after d7 and d6 have been sampled by the slave.
        ra = 7'($urandom);
        rv = 8'($urandom);
        req = 1'b1; we = 1'b1; addr = ra; wr_data = rv;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_ready", 32'(ready), 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_pre_mosi", 32'(spi_mosi), 32'(rv[5]));
        reset_l = 1'b0;
        #1;
        check("abort_mosi", 32'(spi_mosi), 0);
        check("abort_ready_low", 32'(ready), 0);
        ref_mem[ra[6:2]] = rv & 8'hC0;
        req = 1'b1; we = 1'b0; addr = ra;
        reset_flush();
        check("abort_slv_wr_cnt", slv_wr_q.size(), 1);
        if (slv_wr_q.size() > 0)
            check("abort_slv_wr", 32'(slv_wr_q.pop_front()), 32'({ra[6:2], rv & 8'hC0}));
        txn(1'b0, ra, 8'h00, 1'b0);
        check("abort_first_accept", 32'(last_acc - rel), FLUSH_CYCLES + 1);

        repeat (5) @(posedge clk);
        #1;
        check("slv_rd_total", slv_rd_cnt, exp_rd_cnt);
        check("slv_wr_left", slv_wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
